branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter FETCH_W, default 2, meaning slots predicted per lookup (1..4).
REQ-002 SHALL have parameter ENTRIES, default 2048, meaning table entries (power of two); IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter PC_W, default 13, meaning word-address PC width; TAG_W = PC_W-IDX_W (min 1).
REQ-004 SHALL have parameter GHR_W, default 8, meaning global-history length (<= IDX_W).
REQ-005 CLK  in  1  sole clock, rising edge.
REQ-006 RST  in  1  reset, asynchronous, active-high.
REQ-007 lookup_valid  in  1  lookup request this cycle.
REQ-008 lookup_pc  in  PC_W  PC of slot 0; slot i PC = lookup_pc+i, modulo 2^PC_W.
REQ-009 ready  out  1  table initialised, lookups/updates accepted.
REQ-010 pred_valid  out  FETCH_W  per-slot result valid.
REQ-011 pred_taken  out  FETCH_W  per-slot predicted taken.
REQ-012 pred_target  out  FETCH_W*PC_W  per-slot target, slot i at bits [i*PC_W +: PC_W].
REQ-013 update_en  in  1  resolved-branch update strobe.
REQ-014 update_pc  in  PC_W  resolved branch PC.
REQ-015 update_taken  in  1  resolved direction.
REQ-016 update_target  in  PC_W  resolved target.

Function
REQ-017 Entry SHALL hold valid, tag[TAG_W], ctr[2], target[PC_W]; idx = pc[IDX_W-1:0], tag = pc[PC_W-1:IDX_W].
REQ-018 FSM SHALL have states INIT and RUN; INIT writes valid=0, ctr=01 to one entry per cycle, index 0 upward; after ENTRIES cycles -> RUN; ready=1 only in RUN.
REQ-019 Lookup latency SHALL be exactly 1 cycle: request at edge N, pred_* valid after edge N+1, held for one cycle only.
REQ-020 pred_taken[i] SHALL be 1 iff entry valid, tag matches, ctr[1]=1; pred_target[i] = entry target when taken, else slot PC+1.
REQ-021 pred_valid SHALL set slot 0 and every slot up to and including the first predicted-taken slot; later slots 0.
REQ-022 Lookups with ready=0 or lookup_valid=0 SHALL give pred_valid=0 next cycle.
REQ-023 Update on tag hit SHALL saturate ctr (+1 if taken, max 11; -1 if not, min 00); target written only when taken.
REQ-024 Update on miss/invalid SHALL allocate: valid=1, new tag, ctr=10 if taken else 01, target=update_target.
REQ-025 update_en with ready=0 SHALL be ignored.
REQ-026 Same-cycle lookup and update to the same index SHALL return pre-update contents (read-before-write).
REQ-027 Slot PC wrap past 2^PC_W-1 SHALL wrap to 0 without error.

Reset
REQ-028 RST SHALL force state INIT, init counter 0, ready=0, pred_valid=0, pred_taken=0, pred_target=0, GHR=0.
REQ-029 RST asserted mid-INIT or mid-RUN SHALL restart the full sweep from index 0.

Configuration
REQ-030 With BP_GSHARE_EN defined, index SHALL be pc[IDX_W-1:0] XOR zero-extended GHR; GHR shifts in update_taken on each accepted update (LSB newest); tag unchanged.
REQ-031 Without BP_GSHARE_EN, no GHR register SHALL exist and index = pc[IDX_W-1:0].

Structure
REQ-032 Package bp_pkg SHALL hold ctr encodings (SNT=00, WNT=01, WT=10, ST=11) and the entry struct/typedef.
REQ-033 Storage SHALL be sub-module bp_table: ENTRIES deep, FETCH_W synchronous read ports, one write port; FSM, hit logic, slot masking in branch_predictor.

Verification
REQ-034 RST pulse, defaults -> ready=0 for exactly 2048 cycles after release, then 1; pred_valid=0 throughout.
REQ-035 Update pc=0x010 taken target=0x080, then lookup 0x00F -> pred_valid=11, pred_taken=10, slot1 target 0x080.
REQ-036 Three not-taken updates pc=0x010 after allocation -> ctr 10->01->00->00; lookup 0x010 -> taken=0, target 0x011.
REQ-037 Alias: allocate pc=0x010 taken; lookup 0x810 (same idx, tag differs) -> taken=0; update 0x810 not taken -> entry retagged, ctr=01.
REQ-038 Same-cycle lookup 0x010 and update 0x010 taken on ctr=01 -> predicts not taken; next lookup predicts taken.
REQ-039 RST at INIT cycle 1000 -> ready rises 2048 cycles after release; with BP_GSHARE_EN, GHR=0 afterwards.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: counter encodings, FSM states, table entry.
package bp_pkg;

  // Widest PC the entry struct can carry; the table stores only the configured widths.
  localparam int BP_MAX_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bpState_t;

  typedef struct packed {
    logic                valid;
    logic [BP_MAX_W-1:0] tag;
    ctr_t                ctr;
    logic [BP_MAX_W-1:0] target;
  } entry_t;

  function automatic ctr_t ctrSat(ctr_t c, logic taken);
    if (taken) return (c == ST)  ? ST  : ctr_t'(c + 2'd1);
    else       return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Predictor storage: FETCH_W synchronous read ports, one read-modify-write update port.
module bp_table
  import bp_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int ENTRIES = 2048,
  parameter int PC_W    = 13,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = PC_W - IDX_W
) (
  input  logic                            clk,
  input  logic [FETCH_W-1:0][IDX_W-1:0]   rdIdx,
  output entry_t [FETCH_W-1:0]            rdEnt,
  input  logic                            initEn,
  input  logic                            updEn,
  input  logic [IDX_W-1:0]                wrIdx,
  input  logic [TAG_W-1:0]                wrTag,
  input  logic                            wrTaken,
  input  logic [PC_W-1:0]                 wrTarget
);

  logic             validMem [ENTRIES];
  logic [TAG_W-1:0] tagMem   [ENTRIES];
  ctr_t             ctrMem   [ENTRIES];
  logic [PC_W-1:0]  tgtMem   [ENTRIES];

  logic wrHit;
  assign wrHit = validMem[wrIdx] && (tagMem[wrIdx] == wrTag);

  // Nonblocking reads and writes on the same edge give read-before-write to lookups.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      rdEnt[i].valid  <= validMem[rdIdx[i]];
      rdEnt[i].tag    <= BP_MAX_W'(tagMem[rdIdx[i]]);
      rdEnt[i].ctr    <= ctrMem[rdIdx[i]];
      rdEnt[i].target <= BP_MAX_W'(tgtMem[rdIdx[i]]);
    end
  end

  always_ff @(posedge clk) begin
    if (initEn) begin
      validMem[wrIdx] <= 1'b0;
      ctrMem[wrIdx]   <= WNT;
    end else if (updEn) begin
      if (wrHit) begin
        ctrMem[wrIdx] <= ctrSat(ctrMem[wrIdx], wrTaken);
        if (wrTaken) tgtMem[wrIdx] <= wrTarget;
      end else begin
        validMem[wrIdx] <= 1'b1;
        tagMem[wrIdx]   <= wrTag;
        ctrMem[wrIdx]   <= wrTaken ? WT : WNT;
        tgtMem[wrIdx]   <= wrTarget;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Tagged 2-bit-counter branch predictor with FETCH_W slots per lookup and an init sweep.
// Define BP_GSHARE_EN to XOR a global history register into the table index.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int FETCH_W = 2,
  parameter int ENTRIES = 2048,
  parameter int PC_W    = 13,
  parameter int GHR_W   = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       lookup_valid,
  input  logic [PC_W-1:0]            lookup_pc,
  output logic                       ready,
  output logic [FETCH_W-1:0]         pred_valid,
  output logic [FETCH_W-1:0]         pred_taken,
  output logic [FETCH_W*PC_W-1:0]    pred_target,
  input  logic                       update_en,
  input  logic [PC_W-1:0]            update_pc,
  input  logic                       update_taken,
  input  logic [PC_W-1:0]            update_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  if (GHR_W > IDX_W || GHR_W < 1) begin : gBadGhr
    $error("GHR_W must be in 1..IDX_W");
  end
  if (TAG_W < 1) begin : gBadTag
    $error("PC_W must exceed log2(ENTRIES)");
  end

  bpState_t         state, stateNext;
  logic [IDX_W-1:0] initCnt;
  logic             tblInit, tblUpd;
  logic [IDX_W-1:0] histIdx, wrIdx;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0] ghr;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   ghr <= '0;
    else if (update_en && ready) ghr <= GHR_W'({ghr, update_taken});
  end
  assign histIdx = IDX_W'(ghr);
`else
  assign histIdx = '0;
`endif

  // Init sweep FSM
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= INIT;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (state == INIT && initCnt == IDX_W'(ENTRIES - 1)) stateNext = RUN;
  end

  always_comb begin
    ready   = (state == RUN);
    tblInit = (state == INIT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)          initCnt <= '0;
    else if (tblInit) initCnt <= initCnt + 1'b1;
  end

  assign tblUpd = update_en && ready;
  assign wrIdx  = tblInit ? initCnt : (update_pc[IDX_W-1:0] ^ histIdx);

  // Lookup request stage
  logic                            lkVld;
  logic [PC_W-1:0]                 lkPc;
  logic [FETCH_W-1:0][IDX_W-1:0]   rdIdx;
  logic [FETCH_W-1:0][PC_W-1:0]    rdSlotPc;
  logic [FETCH_W-1:0]              slotHit;
  entry_t [FETCH_W-1:0]            rdEnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lkVld <= 1'b0;
      lkPc  <= '0;
    end else begin
      lkVld <= lookup_valid && ready;
      lkPc  <= lookup_pc;
    end
  end

  for (genvar i = 0; i < FETCH_W; i++) begin : gSlot
    logic [PC_W-1:0] reqPc;
    assign reqPc       = lookup_pc + PC_W'(i);
    assign rdIdx[i]    = reqPc[IDX_W-1:0] ^ histIdx;
    assign rdSlotPc[i] = lkPc + PC_W'(i);
    assign slotHit[i]  = rdEnt[i].valid
                      && (rdEnt[i].tag == BP_MAX_W'(rdSlotPc[i][PC_W-1:IDX_W]))
                      && (rdEnt[i].ctr == WT || rdEnt[i].ctr == ST);
  end

  bp_table #(
    .FETCH_W (FETCH_W),
    .ENTRIES (ENTRIES),
    .PC_W    (PC_W),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) uTable (
    .clk      (CLK),
    .rdIdx    (rdIdx),
    .rdEnt    (rdEnt),
    .initEn   (tblInit),
    .updEn    (tblUpd),
    .wrIdx    (wrIdx),
    .wrTag    (update_pc[PC_W-1:IDX_W]),
    .wrTaken  (update_taken),
    .wrTarget (update_target)
  );

  // Slots after the first predicted-taken one are fetch-dead and masked to zero.
  logic reach;
  always_comb begin
    pred_valid  = '0;
    pred_taken  = '0;
    pred_target = '0;
    reach       = lkVld;
    for (int i = 0; i < FETCH_W; i++) begin
      if (reach) begin
        pred_valid[i]                 = 1'b1;
        pred_taken[i]                 = slotHit[i];
        pred_target[i*PC_W +: PC_W]   = slotHit[i] ? rdEnt[i].target[PC_W-1:0]
                                                   : rdSlotPc[i] + PC_W'(1);
      end
      reach = reach && !slotHit[i];
    end
  end

endmodule
